fpu_norm_pipe: RTL and testbench
================================

FPU_NORM_PIPE -- requirements
Module: fpu_norm_pipe

Interface
REQ-001 SHALL have parameter WIDTH, default 106: operand width in bits.
REQ-002 SHALL have parameter WIDTH_LOG, default 7: index width in bits; legal only when 2^(WIDTH_LOG-1) < WIDTH <= 2^WIDTH_LOG.
REQ-003 SHALL have parameter TAG_W, default 4: sideband tag width in bits.
REQ-004 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1 bit: an input beat is offered.
REQ-007 SHALL have port in_ready, output, 1 bit: the block accepts the offered beat.
REQ-008 SHALL have port in_value, input, WIDTH bits: operand.
REQ-009 SHALL have port in_mode, input, 1 bit: 0 = leading-one search, 1 = trailing-one search.
REQ-010 SHALL have port in_tag, input, TAG_W bits: opaque sideband, returned unchanged with the result.
REQ-011 SHALL have port out_valid, input-side counterpart output, 1 bit: a result beat is presented.
REQ-012 SHALL have port out_ready, input, 1 bit: the consumer accepts the presented beat.
REQ-013 SHALL have port out_index, output, WIDTH_LOG bits: bit position of the found one.
REQ-014 SHALL have port out_shift, output, WIDTH_LOG bits: shift amount applied to the operand.
REQ-015 SHALL have port out_norm, output, WIDTH bits: normalised operand.
REQ-016 SHALL have port out_zero, output, 1 bit: the operand was all-zero.
REQ-017 SHALL have port out_tag, output, TAG_W bits: tag of the result beat.
REQ-018 SHALL have port occupancy, output, 2 bits: number of valid pipeline stages, 0 to 2.

Function
REQ-019 A beat SHALL transfer on the input side on any cycle with in_valid=1 and in_ready=1, and on the output side on any cycle with out_valid=1 and out_ready=1.
REQ-020 The pipeline SHALL have two register stages: S1 captures the operand, mode, tag and search index; S2 captures the shifted result.
REQ-021 Latency from input transfer to out_valid=1 SHALL be exactly 2 cycles when the output side is not stalled.
REQ-022 Sustained throughput SHALL be 1 beat per cycle while out_ready=1.
REQ-023 A stage SHALL load when it is empty or when its contents move downstream in the same cycle.
REQ-024 in_ready SHALL be 1 when S1 is empty or S1 advances into S2 in the same cycle; in_ready SHALL NOT depend on in_valid.
REQ-025 While out_valid=1 and out_ready=0, all out_* values SHALL hold stable.
REQ-026 Beats SHALL leave in acceptance order; no beat SHALL be dropped or duplicated.
REQ-027 Leading mode: out_index SHALL be the highest set bit position, out_shift = WIDTH-1-out_index, and out_norm = in_value << out_shift.
REQ-028 Trailing mode: out_index SHALL be the lowest set bit position, out_shift = out_index, and out_norm = in_value >> out_shift, logical.
REQ-029 Zero operand, either mode: out_zero=1 and out_index=0, out_shift=0, out_norm=0; for a nonzero operand out_zero=0.
REQ-030 occupancy SHALL equal the sum of the S1 and S2 valid bits; a simultaneous input transfer and output transfer SHALL leave occupancy unchanged.

Reset
REQ-031 While rst=1 at a clock edge, S1 and S2 valid bits SHALL clear, so that out_valid=0 and occupancy=0 the next cycle, and in-flight beats are discarded.
REQ-032 After that edge, out_index, out_shift, out_norm, out_zero and out_tag SHALL read 0.
REQ-033 in_ready SHALL be 0 while rst=1 and SHALL be 1 in the first cycle after rst is released.

Structure
REQ-034 A shared package fpu_norm_pkg SHALL hold the MODE_LEAD and MODE_TRAIL constants and the width-legality check function.
REQ-035 The combinational binary-search one-detector SHALL be a sub-module, fpu_lod_comb, parameterised by WIDTH, WIDTH_LOG and direction; it returns the index and the zero flag.
REQ-036 An illegal WIDTH/WIDTH_LOG combination SHALL cause an elaboration error.

Verification (WIDTH=106, WIDTH_LOG=7)
REQ-037 Leading mode, in_value=2^105, out_ready=1 -> 2 cycles later: out_index=105, out_shift=0, out_norm=2^105, out_zero=0.
REQ-038 Leading mode, in_value=1 -> out_index=0, out_shift=105, out_norm=2^105; trailing mode, in_value=0x58 -> out_index=3, out_shift=3, out_norm=0xB.
REQ-039 in_value=0, both modes -> out_zero=1, out_index=0, out_shift=0, out_norm=0.
REQ-040 Backpressure: 4 back-to-back beats with tags 1 to 4 while out_ready=0 -> in_ready=0 after 2 accepted, occupancy=2, outputs stable; out_ready=1 then releases tags 1 to 4 in order with no loss.
REQ-041 Reset mid-operation: rst=1 for 1 cycle with occupancy=2 -> next cycle out_valid=0 and occupancy=0; in_ready=1 on the first cycle after release.
REQ-042 Random streaming: 10k beats with random valid/ready and mode -> results match a reference model and output count equals input count.

Source files
------------

// File: rtl/fpu_norm_pkg.sv
// Shared definitions for the normalisation pipeline: search-direction
// encodings and the operand/index width legality rule.
package fpu_norm_pkg;

  localparam logic MODE_LEAD  = 1'b0;
  localparam logic MODE_TRAIL = 1'b1;

  // An index of width_log bits must cover every bit position of the operand,
  // and must not carry a whole unused top bit.
  function automatic bit width_ok(input int width, input int width_log);
    return ((1 << (width_log - 1)) < width) && (width <= (1 << width_log));
  endfunction

endpackage

// File: rtl/fpu_lod_comb.sv
// Combinational binary-search one detector. The operand is zero-padded to a
// power of two; each level halves the search window and decides one index
// bit, MSB first. DIR selects leading-one or trailing-one search.
module fpu_lod_comb #(
  parameter int   WIDTH     = 106,
  parameter int   WIDTH_LOG = 7,
  parameter logic DIR       = 1'b0
) (
  input  logic [WIDTH-1:0]     value,
  output logic [WIDTH_LOG-1:0] index,
  output logic                 zero
);
  import fpu_norm_pkg::*;

  localparam int N = 1 << WIDTH_LOG;
  localparam logic [N-1:0] ONE = {{(N-1){1'b0}}, 1'b1};

  logic [N-1:0]         padded;
  logic [N-1:0]         win;
  logic [N-1:0]         low_mask;
  logic [WIDTH_LOG-1:0] idx;

  // Window always sits in the low bits; after each level it is narrowed to
  // the half that holds the wanted one and shifted down when that half is
  // the upper one.
  always_comb begin
    padded              = '0;
    padded[WIDTH-1:0]   = value;
    win                 = padded;
    idx                 = '0;
    low_mask            = '0;
    for (int b = WIDTH_LOG - 1; b >= 0; b--) begin
      low_mask = (ONE << (1 << b)) - ONE;
      if (DIR == MODE_TRAIL) begin
        if ((win & low_mask) == '0) begin
          idx[b] = 1'b1;
          win    = win >> (1 << b);
        end else begin
          win = win & low_mask;
        end
      end else begin
        if ((win & ~low_mask) != '0) begin
          idx[b] = 1'b1;
          win    = win >> (1 << b);
        end else begin
          win = win & low_mask;
        end
      end
    end
  end

  // A zero operand reports index 0 regardless of search direction.
  assign zero  = ~|value;
  assign index = zero ? '0 : idx;

endmodule

// File: rtl/fpu_norm_pipe.sv
// Two-stage normalisation pipeline. S1 registers the operand together with
// its leading/trailing one index; S2 registers the shift amount and the
// shifted operand.
//
// Handshake: a beat moves on any rising edge where valid and ready are both
// high on that side. in_ready is computed from pipeline state only (never
// from in_valid); once out_valid is high the out_* payload holds until
// out_ready takes it.
module fpu_norm_pipe #(
  parameter int WIDTH     = 106,
  parameter int WIDTH_LOG = 7,
  parameter int TAG_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     in_value,
  input  logic                 in_mode,
  input  logic [TAG_W-1:0]     in_tag,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH_LOG-1:0] out_index,
  output logic [WIDTH_LOG-1:0] out_shift,
  output logic [WIDTH-1:0]     out_norm,
  output logic                 out_zero,
  output logic [TAG_W-1:0]     out_tag,
  output logic [1:0]           occupancy
);
  import fpu_norm_pkg::*;

  if (!width_ok(WIDTH, WIDTH_LOG)) begin : g_bad_width
    $error("fpu_norm_pipe: WIDTH does not fit WIDTH_LOG");
  end

  localparam logic [WIDTH_LOG-1:0] TOP_IDX = WIDTH_LOG'(WIDTH - 1);

  logic [WIDTH_LOG-1:0] lead_idx, trail_idx;
  logic                 lead_zero, trail_zero;

  logic                 s1_valid;
  logic [WIDTH-1:0]     s1_value;
  logic                 s1_mode;
  logic [TAG_W-1:0]     s1_tag;
  logic [WIDTH_LOG-1:0] s1_index;
  logic                 s1_zero;

  logic [WIDTH_LOG-1:0] s1_shift;
  logic [WIDTH-1:0]     s1_norm;

  logic                 s2_valid;
  logic                 s2_load_ok;

  fpu_lod_comb #(
    .WIDTH     (WIDTH),
    .WIDTH_LOG (WIDTH_LOG),
    .DIR       (MODE_LEAD)
  ) u_lod_lead (
    .value (in_value),
    .index (lead_idx),
    .zero  (lead_zero)
  );

  fpu_lod_comb #(
    .WIDTH     (WIDTH),
    .WIDTH_LOG (WIDTH_LOG),
    .DIR       (MODE_TRAIL)
  ) u_lod_trail (
    .value (in_value),
    .index (trail_idx),
    .zero  (trail_zero)
  );

  // S2 can take a beat when empty or when its beat leaves this cycle; S1 can
  // then take one when empty or when it moves into S2.
  assign s2_load_ok = !s2_valid || out_ready;
  assign in_ready   = !rst && (!s1_valid || s2_load_ok);
  assign out_valid  = s2_valid;
  assign occupancy  = {1'b0, s1_valid} + {1'b0, s2_valid};

  // S1: capture operand, mode, tag and the direction-selected search result.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_value <= '0;
      s1_mode  <= MODE_LEAD;
      s1_tag   <= '0;
      s1_index <= '0;
      s1_zero  <= 1'b0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_value <= in_value;
        s1_mode  <= in_mode;
        s1_tag   <= in_tag;
        s1_index <= (in_mode == MODE_TRAIL) ? trail_idx : lead_idx;
        s1_zero  <= (in_mode == MODE_TRAIL) ? trail_zero : lead_zero;
      end
    end
  end

  // Shift amount and normalised operand from the S1 contents; zero operands
  // produce an all-zero result.
  always_comb begin
    s1_shift = '0;
    s1_norm  = '0;
    if (!s1_zero) begin
      if (s1_mode == MODE_TRAIL) begin
        s1_shift = s1_index;
        s1_norm  = s1_value >> s1_index;
      end else begin
        s1_shift = TOP_IDX - s1_index;
        s1_norm  = s1_value << s1_shift;
      end
    end
  end

  // S2: result register driving the output side; payload only changes when
  // a real beat advances out of S1.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid  <= 1'b0;
      out_index <= '0;
      out_shift <= '0;
      out_norm  <= '0;
      out_zero  <= 1'b0;
      out_tag   <= '0;
    end else if (s2_load_ok) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        out_index <= s1_index;
        out_shift <= s1_shift;
        out_norm  <= s1_norm;
        out_zero  <= s1_zero;
        out_tag   <= s1_tag;
      end
    end
  end

endmodule

// File: tb/tb_fpu_norm_pipe.sv
// Bench for fpu_norm_pipe: directed vectors, backpressure, mid-stream reset
// and a random valid/ready stream, all checked against a bit-scan model.
module tb_fpu_norm_pipe;

  localparam int W     = 106;
  localparam int WL    = 7;
  localparam int TW    = 4;
  localparam int EXP_W = WL + WL + W + 1 + TW;
  localparam int N_RAND = 10000;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_value;
  logic          in_mode;
  logic [TW-1:0] in_tag;
  logic          out_valid;
  logic          out_ready;
  logic [WL-1:0] out_index;
  logic [WL-1:0] out_shift;
  logic [W-1:0]  out_norm;
  logic          out_zero;
  logic [TW-1:0] out_tag;
  logic [1:0]    occupancy;

  int checks;
  int failures;
  int in_cnt;
  int out_cnt;

  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] prev_out;
  bit               prev_stall;

  fpu_norm_pipe #(
    .WIDTH     (W),
    .WIDTH_LOG (WL),
    .TAG_W     (TW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_value  (in_value),
    .in_mode   (in_mode),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_index (out_index),
    .out_shift (out_shift),
    .out_norm  (out_norm),
    .out_zero  (out_zero),
    .out_tag   (out_tag),
    .occupancy (occupancy)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: plain linear bit scan.
  function automatic logic [EXP_W-1:0] model(input logic [W-1:0] v, input logic m,
                                             input logic [TW-1:0] t);
    int idx;
    int sh;
    logic [W-1:0] n;
    idx = 0;
    if (v == '0) return {{WL{1'b0}}, {WL{1'b0}}, {W{1'b0}}, 1'b1, t};
    if (m == 1'b0) begin
      for (int i = 0; i < W; i++) if (v[i]) idx = i;
      sh = W - 1 - idx;
      n  = v << sh;
    end else begin
      for (int i = W - 1; i >= 0; i--) if (v[i]) idx = i;
      sh = idx;
      n  = v >> sh;
    end
    return {WL'(idx), WL'(sh), n, 1'b0, t};
  endfunction

  function automatic logic [W-1:0] rand_val();
    logic [127:0] r;
    logic [W-1:0] v;
    int sel;
    r   = {$urandom(), $urandom(), $urandom(), $urandom()};
    v   = r[W-1:0];
    sel = $urandom_range(0, 5);
    case (sel)
      0:       return '0;
      1:       return W'(1) << $urandom_range(0, W - 1);
      2:       return v >> $urandom_range(0, W - 1);
      3:       return v << $urandom_range(0, W - 1);
      default: return v;
    endcase
  endfunction

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [EXP_W-1:0] got;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      got = {out_index, out_shift, out_norm, out_zero, out_tag};
      if (prev_stall && out_valid) check("hold_stable", got, prev_out);
      if (in_valid && in_ready) begin
        exp_q.push_back(model(in_value, in_mode, in_tag));
        in_cnt++;
      end
      if (out_valid && out_ready) begin
        check("exp_available", 128'(exp_q.size() != 0), 128'(1));
        if (exp_q.size() != 0) check("result", got, exp_q.pop_front());
        out_cnt++;
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = got;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [W-1:0] v, input logic m, input logic [TW-1:0] t);
    bit acc;
    int n;
    in_valid = 1'b1;
    in_value = v;
    in_mode  = m;
    in_tag   = t;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 100) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      n++;
    end
    check("send_accepted", 128'(acc), 128'(1));
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || occupancy != 2'd0) && n < 500) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_queue_empty", 128'(exp_q.size()), 128'(0));
    check("drain_occupancy", 128'(occupancy), 128'(0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [W-1:0]  p105;
    logic [W-1:0]  ones;
    logic [TW-1:0] nt;
    bit            acc;
    int            sent;

    checks = 0; failures = 0; in_cnt = 0; out_cnt = 0;
    prev_stall = 1'b0;
    rst = 1'b1; in_valid = 1'b0; in_value = '0; in_mode = 1'b0; in_tag = '0;
    out_ready = 1'b0;
    p105 = '0; p105[105] = 1'b1;
    ones = '1;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 128'(in_ready), 128'(0));
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_occupancy", 128'(occupancy), 128'(0));
    check("rst_payload", 128'({out_index, out_shift, out_norm, out_zero, out_tag}), 128'(0));
    rst = 1'b0;
    #1;
    check("release_in_ready", 128'(in_ready), 128'(1));

    // Directed: first beat also checks 2-cycle latency and exact values
    out_ready = 1'b1;
    send(p105, 1'b0, 4'd1);
    check("lat_after_1", 128'(out_valid), 128'(0));
    @(posedge clk);
    #1;
    check("lat_after_2", 128'(out_valid), 128'(1));
    check("msb_index", 128'(out_index), 128'(105));
    check("msb_shift", 128'(out_shift), 128'(0));
    check("msb_norm", 128'(out_norm), 128'(p105));
    check("msb_zero", 128'(out_zero), 128'(0));

    send(W'(1), 1'b0, 4'd2);
    send(W'(8'h58), 1'b1, 4'd3);
    send('0, 1'b0, 4'd4);
    send('0, 1'b1, 4'd5);
    send(ones, 1'b1, 4'd6);
    send(ones, 1'b0, 4'd7);
    send(W'(1), 1'b1, 4'd8);
    send(p105, 1'b1, 4'd9);
    drain();

    // Backpressure: offer tags 1..4 with out_ready low
    out_ready = 1'b0;
    nt = 4'd1;
    for (int c = 0; c < 6; c++) begin
      in_valid = 1'b1; in_value = rand_val(); in_mode = 1'(c); in_tag = nt;
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) nt = nt + 4'd1;
    end
    check("bp_accepted", 128'(nt), 128'(3));
    check("bp_in_ready", 128'(in_ready), 128'(0));
    check("bp_occupancy", 128'(occupancy), 128'(2));
    check("bp_out_valid", 128'(out_valid), 128'(1));
    check("bp_head_tag", 128'(out_tag), 128'(1));
    out_ready = 1'b1;
    while (nt <= 4'd4) begin
      in_valid = 1'b1; in_value = rand_val(); in_mode = 1'(nt); in_tag = nt;
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      if (acc) nt = nt + 4'd1;
    end
    drain();

    // Reset with a full pipeline
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1; in_value = rand_val(); in_mode = 1'b0; in_tag = 4'(c);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    check("pre_rst_occupancy", 128'(occupancy), 128'(2));
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_out_valid", 128'(out_valid), 128'(0));
    check("mid_rst_occupancy", 128'(occupancy), 128'(0));
    check("mid_rst_in_ready", 128'(in_ready), 128'(0));
    exp_q.delete();
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 128'(in_ready), 128'(1));
    @(posedge clk);
    #1;

    // Random stream
    in_cnt = 0; out_cnt = 0; sent = 0;
    acc = 1'b0;
    while (sent < N_RAND) begin
      if (!in_valid || acc) begin
        if ($urandom_range(0, 3) != 0) begin
          in_valid = 1'b1;
          in_value = rand_val();
          in_mode  = 1'($urandom_range(0, 1));
          in_tag   = TW'($urandom_range(0, 15));
        end else begin
          in_valid = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc) sent++;
      @(posedge clk);
      #1;
    end
    drain();
    check("rand_in_count", 128'(in_cnt), 128'(N_RAND));
    check("rand_out_count", 128'(out_cnt), 128'(in_cnt));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
